// File: rtl/glb_req_arbiter.sv
// glb_req_arbiter
// Round-robin arbiter that shares the single GLB processor-side port among
// NUM_REQ test-app requesters. One requester owns the port for a burst of
// 64-bit word beats; each accepted beat becomes one registered GLB write or
// read strobe. Read data returns RD_LATENCY cycles after glb_rd_en and is
// tagged back to the requester that issued it.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     per-requester beat handshake (ready is one-hot or 0)
//   req_wr, req_last    beat direction (1=write) and end-of-burst marker
//   req_addr, req_wdata packed per-requester byte address / write data
//   rsp_valid, rsp_data read return strobe (per requester) and shared data
//   glb_wr_*, glb_rd_*  GLB processor-side write / read port
module glb_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int GLB_ADDR_WIDTH  = 22,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int RD_LATENCY      = 4,
  parameter int MAX_BURST       = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_wr,
  input  logic [NUM_REQ-1:0]                  req_last,
  input  logic [NUM_REQ*GLB_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [BANK_DATA_WIDTH-1:0]          rsp_data,
  output logic                                glb_wr_en,
  output logic [GLB_ADDR_WIDTH-1:0]           glb_wr_addr,
  output logic [BANK_DATA_WIDTH-1:0]          glb_wr_data,
  output logic                                glb_rd_en,
  output logic [GLB_ADDR_WIDTH-1:0]           glb_rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0]          glb_rd_data
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic                       wr_en_q, rd_en_q;
  logic [GLB_ADDR_WIDTH-1:0]  wr_addr_q, rd_addr_q;
  logic [BANK_DATA_WIDTH-1:0] wr_data_q;

  // Read-tag pipeline: stage 0 lines up with glb_rd_en, stage RD_LATENCY
  // lines up with the returning glb_rd_data.
  logic [RD_LATENCY:0]          rd_vld_q;
  logic [RD_LATENCY:0][IDW-1:0] rd_id_q;

  // Per-requester word-aligned address and write data.
  logic [GLB_ADDR_WIDTH-1:0]  addr_al [NUM_REQ];
  logic [BANK_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [NUM_REQ*3-1:0]       unused_addr_lo;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_al[g]   = {req_addr[g*GLB_ADDR_WIDTH+3 +: GLB_ADDR_WIDTH-3], 3'b000};
    assign wdata_arr[g] = req_wdata[g*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
    assign unused_addr_lo[g*3 +: 3] = req_addr[g*GLB_ADDR_WIDTH +: 3];
  end

  // Round-robin search starting one past the previous owner, with wrap.
  logic           win_found;
  logic [IDW-1:0] win_id;
  int             cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!win_found && req_valid[IDW'(cand)]) begin
        win_found = 1'b1;
        win_id    = IDW'(cand);
      end
    end
  end

  logic            hs, own_wr, burst_end;
  logic [CNTW-1:0] cnt_nxt;

  assign hs        = (state_q == S_BURST) & req_valid[owner_q];
  assign own_wr    = req_wr[owner_q];
  assign cnt_nxt   = cnt_q + CNTW'(1);
  // Forced release on the beat that brings the count to MAX_BURST.
  assign burst_end = hs & (req_last[owner_q] | (cnt_nxt == CNTW'(MAX_BURST)));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_id;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      default: begin
        if (hs) begin
          cnt_d = cnt_nxt;
          if (burst_end) begin
            last_d  = owner_q;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_BURST) req_ready[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      rd_vld_q  <= '0;
      rd_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= hs & own_wr;
      rd_en_q   <= hs & ~own_wr;
      wr_addr_q <= (hs & own_wr)  ? addr_al[owner_q]   : '0;
      wr_data_q <= (hs & own_wr)  ? wdata_arr[owner_q] : '0;
      rd_addr_q <= (hs & ~own_wr) ? addr_al[owner_q]   : '0;
      rd_vld_q  <= {rd_vld_q[RD_LATENCY-1:0], hs & ~own_wr};
      rd_id_q   <= {rd_id_q[RD_LATENCY-1:0], owner_q};
    end
  end

  assign glb_wr_en   = wr_en_q;
  assign glb_rd_en   = rd_en_q;
  assign glb_wr_addr = wr_addr_q;
  assign glb_wr_data = wr_data_q;
  assign glb_rd_addr = rd_addr_q;

  always_comb begin
    rsp_valid = '0;
    if (rd_vld_q[RD_LATENCY]) rsp_valid[rd_id_q[RD_LATENCY]] = 1'b1;
  end

  // Data is gated so the output reads zero whenever no response is due.
  assign rsp_data = rd_vld_q[RD_LATENCY] ? glb_rd_data : '0;

endmodule

// File: tb/tb_glb_req_arbiter.sv
// Testbench for glb_req_arbiter: a cycle table for single write, alignment
// and read return, then scoreboard-driven multi-requester sequences for
// round-robin order, forced release and reset in the middle of a burst.
module tb_glb_req_arbiter;
  localparam int NR = 4, AW = 22, DW = 64, RL = 4, MB = 16;
  localparam logic [DW-1:0] G = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NR-1:0]     req_valid, req_ready, req_wr, req_last, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_data, glb_wr_data, glb_rd_data;
  logic              glb_wr_en, glb_rd_en;
  logic [AW-1:0]     glb_wr_addr, glb_rd_addr;

  glb_req_arbiter #(.NUM_REQ(NR), .GLB_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW),
                    .RD_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .glb_wr_en(glb_wr_en), .glb_wr_addr(glb_wr_addr), .glb_wr_data(glb_wr_data),
    .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr), .glb_rd_data(glb_rd_data)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, last_hs = 0;

  typedef struct packed {
    logic [NR-1:0] v, wr, last;
    logic [AW-1:0] addr;
    logic [DW-1:0] d, rdd;
    logic [NR-1:0] e_rdy;
    logic          e_wen, e_ren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [NR-1:0] e_rsp;
    logic [DW-1:0] e_rd;
  } vec_t;

  typedef struct packed { logic wr; logic last; logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;
  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; int due; } op_t;
  typedef struct packed { logic [NR-1:0] id; logic [DW-1:0] data; int due; } rsp_t;

  vec_t  tbl [15];
  beat_t bq [NR][$];
  op_t   q_glb [$];
  rsp_t  q_rsp [$];
  int    exp_gid [$], exp_gdt [$];
  logic [DW-1:0] slot_d [8];
  bit            slot_v [8];

  function automatic vec_t mk(input logic [NR-1:0] v, wr, l, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, rdd, input logic [NR-1:0] erdy,
                              input logic ewen, eren, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ewd, input logic [NR-1:0] ersp,
                              input logic [DW-1:0] erd);
    vec_t t;
    t.v = v; t.wr = wr; t.last = l; t.addr = a; t.d = d; t.rdd = rdd;
    t.e_rdy = erdy; t.e_wen = ewen; t.e_ren = eren; t.e_addr = ea;
    t.e_wd = ewd; t.e_rsp = ersp; t.e_rd = erd;
    return t;
  endfunction

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
    return {a, 10'h155, ~a, 10'h2AA};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  // Next cycle; the GLB model puts read data up RL cycles after glb_rd_en.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (slot_v[cyc % 8]) begin
      glb_rd_data = slot_d[cyc % 8];
      slot_v[cyc % 8] = 1'b0;
    end else begin
      glb_rd_data = G;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (bq[i].size() != 0) begin
        req_valid[i] = 1'b1;
        req_wr[i]    = bq[i][0].wr;
        req_last[i]  = bq[i][0].last;
        req_addr[i*AW +: AW]  = bq[i][0].addr;
        req_wdata[i*DW +: DW] = bq[i][0].data;
      end else begin
        req_valid[i] = 1'b0;
        req_wr[i]    = 1'b0;
        req_last[i]  = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_wdata[i*DW +: DW] = '0;
      end
    end
  endtask

  // Called at the negedge: pops scoreboard entries that are due this cycle.
  task automatic check_outputs();
    op_t  e;
    rsp_t r;
    if (q_glb.size() != 0 && q_glb[0].due == cyc) begin
      e = q_glb.pop_front();
      chk("glb_strobe", {glb_wr_en, glb_rd_en}, e.wr ? 2'b10 : 2'b01);
      chk("glb_addr", e.wr ? glb_wr_addr : glb_rd_addr, e.addr);
      if (e.wr) chk("glb_wdata", glb_wr_data, e.data);
    end else begin
      chk("glb_idle", {glb_wr_en, glb_rd_en}, 2'b00);
    end
    if (q_rsp.size() != 0 && q_rsp[0].due == cyc) begin
      r = q_rsp.pop_front();
      chk("rsp_valid", rsp_valid, r.id);
      chk("rsp_data", rsp_data, r.data);
    end else begin
      chk("rsp_idle", rsp_valid, '0);
    end
    chk("ready_onehot0", $onehot0(req_ready), 1);
    if (glb_rd_en) begin
      slot_d[(cyc + RL) % 8] = mem_of(glb_rd_addr);
      slot_v[(cyc + RL) % 8] = 1'b1;
    end
  endtask

  // Runs queued beats until everything drains, stop_hs handshakes occur,
  // or the cycle budget expires. Enters just after a posedge, returns at
  // a negedge.
  task automatic run_sched(input int stop_hs, input int budget);
    int n_hs, n, gi, gd;
    bit busy;
    beat_t b;
    op_t o;
    rsp_t r;
    logic [AW-1:0] al;
    n_hs = 0;
    n = 0;
    forever begin
      drive_reqs();
      @(negedge clk);
      check_outputs();
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          b  = bq[i].pop_front();
          al = {b.addr[AW-1:3], 3'b000};
          o.wr = b.wr; o.addr = al; o.data = b.data; o.due = cyc + 1;
          q_glb.push_back(o);
          if (!b.wr) begin
            r.id = '0; r.id[i] = 1'b1; r.data = mem_of(al); r.due = cyc + 1 + RL;
            q_rsp.push_back(r);
          end
          if (exp_gid.size() == 0) begin
            fail_now($sformatf("grant_extra: requester %0d granted, none expected", i));
          end else begin
            gi = exp_gid.pop_front();
            gd = exp_gdt.pop_front();
            chk("grant_id", i, gi);
            if (gd >= 0) chk("grant_gap", cyc - last_hs, gd);
          end
          last_hs = cyc;
          n_hs++;
        end
      end
      if (stop_hs != 0 && n_hs >= stop_hs) return;
      busy = (q_glb.size() != 0) || (q_rsp.size() != 0);
      for (int i = 0; i < NR; i++) if (bq[i].size() != 0) busy = 1'b1;
      if (!busy) begin
        if (exp_gid.size() != 0) fail_now($sformatf("grant_missing: %0d grants never seen", exp_gid.size()));
        return;
      end
      n++;
      if (n > budget) begin
        fail_now("timeout: scheduled traffic did not drain");
        return;
      end
      advance();
    end
  endtask

  task automatic expect_grant(input int id, input int gap);
    exp_gid.push_back(id);
    exp_gdt.push_back(gap);
  endtask

  task automatic push_beat(input int i, input logic wr, input logic last,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    beat_t b;
    b.wr = wr; b.last = last; b.addr = a; b.data = d;
    bq[i].push_back(b);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_wr = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    glb_rd_data = G;

    // Cycle table after reset release (row i applies during cycle i).
    tbl[0]  = mk(4'h0, 4'h0, 4'h0, 22'h0,   64'h0,    G,        4'h0, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[1]  = mk(4'h2, 4'h2, 4'hF, 22'h100, 64'hDEAD, G,        4'h0, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[2]  = mk(4'h2, 4'h2, 4'hF, 22'h100, 64'hDEAD, G,        4'h2, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[3]  = mk(4'h0, 4'h0, 4'h0, 22'h0,   64'h0,    G,        4'h0, 1, 0, 22'h100, 64'hDEAD, 4'h0, 64'h0);
    tbl[4]  = mk(4'h8, 4'h8, 4'hF, 22'h103, 64'hBEEF, G,        4'h0, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[5]  = mk(4'h8, 4'h8, 4'hF, 22'h103, 64'hBEEF, G,        4'h8, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[6]  = mk(4'h0, 4'h0, 4'h0, 22'h0,   64'h0,    G,        4'h0, 1, 0, 22'h100, 64'hBEEF, 4'h0, 64'h0);
    tbl[7]  = mk(4'h4, 4'h0, 4'hF, 22'h45,  64'h0,    G,        4'h0, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[8]  = mk(4'h4, 4'h0, 4'hF, 22'h45,  64'h0,    G,        4'h4, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[9]  = mk(4'h0, 4'h0, 4'h0, 22'h0,   64'h0,    G,        4'h0, 0, 1, 22'h40,  64'h0,    4'h0, 64'h0);
    tbl[10] = mk(4'h0, 4'h0, 4'h0, 22'h0,   64'h0,    G,        4'h0, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);
    tbl[11] = tbl[10];
    tbl[12] = tbl[10];
    tbl[13] = mk(4'h0, 4'h0, 4'h0, 22'h0,   64'h0,    64'h1234, 4'h0, 0, 0, 22'h0,   64'h0,    4'h4, 64'h1234);
    tbl[14] = mk(4'h0, 4'h0, 4'h0, 22'h0,   64'h0,    64'h5555, 4'h0, 0, 0, 22'h0,   64'h0,    4'h0, 64'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", req_ready, '0);
    chk("reset_strobes", {glb_wr_en, glb_rd_en}, 2'b00);
    chk("reset_wr_addr", glb_wr_addr, '0);
    chk("reset_wr_data", glb_wr_data, '0);
    chk("reset_rd_addr", glb_rd_addr, '0);
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_rsp_data", rsp_data, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int r = 0; r < 15; r++) begin
      req_valid   = tbl[r].v;
      req_wr      = tbl[r].wr;
      req_last    = tbl[r].last;
      req_addr    = {NR{tbl[r].addr}};
      req_wdata   = {NR{tbl[r].d}};
      glb_rd_data = tbl[r].rdd;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_strobes", r), {glb_wr_en, glb_rd_en}, {tbl[r].e_wen, tbl[r].e_ren});
      if (tbl[r].e_wen) begin
        chk($sformatf("tbl%0d_wr_addr", r), glb_wr_addr, tbl[r].e_addr);
        chk($sformatf("tbl%0d_wr_data", r), glb_wr_data, tbl[r].e_wd);
      end
      if (tbl[r].e_ren) chk($sformatf("tbl%0d_rd_addr", r), glb_rd_addr, tbl[r].e_addr);
      chk($sformatf("tbl%0d_rsp_valid", r), rsp_valid, tbl[r].e_rsp);
      if (tbl[r].e_rsp != '0) chk($sformatf("tbl%0d_rsp_data", r), rsp_data, tbl[r].e_rd);
      @(posedge clk);
      #1;
    end

    // Round-robin: everyone streams single-beat bursts; fresh reset so req0 leads.
    req_valid = '0;
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) begin
        push_beat(i, 1'b1, 1'b1, AW'((i << 12) | (k << 4) | (i + k + 1)),
                  {8'(i), 8'(k), 48'hCAFE_0000_BEEF});
        expect_grant(i, (k == 0 && i == 0) ? -1 : 2);
      end
    run_sched(0, 200);
    advance();

    // Forced release: req0 has 20 mixed beats, req1 waits with one write.
    for (int b = 0; b < 20; b++)
      push_beat(0, 1'(b % 2), b == 19, AW'(22'h2000 + b * 8 + (b % 8)), 64'hF0F0_0000_0000_0000 | 64'(b));
    push_beat(1, 1'b1, 1'b1, 22'h3008, 64'h77);
    for (int b = 0; b < 16; b++) expect_grant(0, (b == 0) ? -1 : 1);
    expect_grant(1, 2);
    expect_grant(0, 2);
    for (int b = 0; b < 3; b++) expect_grant(0, 1);
    run_sched(0, 200);
    advance();

    // Reset mid-burst with three reads in flight.
    for (int b = 0; b < 6; b++) push_beat(2, 1'b0, 1'b0, AW'(22'h300 + b * 8), 64'h0);
    expect_grant(2, -1);
    expect_grant(2, 1);
    expect_grant(2, 1);
    run_sched(3, 50);
    advance();
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check_outputs();
    q_glb.delete();
    q_rsp.delete();
    exp_gid.delete();
    exp_gdt.delete();
    for (int i = 0; i < NR; i++) bq[i].delete();
    advance();
    @(negedge clk);
    chk("midrst_ready", req_ready, '0);
    chk("midrst_strobes", {glb_wr_en, glb_rd_en}, 2'b00);
    chk("midrst_wr_addr", glb_wr_addr, '0);
    chk("midrst_wr_data", glb_wr_data, '0);
    chk("midrst_rd_addr", glb_rd_addr, '0);
    chk("midrst_rsp_valid", rsp_valid, '0);
    chk("midrst_rsp_data", rsp_data, '0);
    advance();
    @(negedge clk);
    chk("midrst_rsp_valid2", rsp_valid, '0);
    advance();
    reset = 1'b0;
    push_beat(0, 1'b1, 1'b1, 22'h505, 64'h55);
    push_beat(2, 1'b0, 1'b1, 22'h610, 64'h0);
    expect_grant(0, -1);
    expect_grant(2, 2);
    run_sched(0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
